// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - Shared types and constants for the SAP control sequencer.
package sap_pkg;

    typedef struct packed {
        logic hlt;
        logic mi;
        logic ri;
        logic ro;
        logic io;
        logic ii;
        logic ai;
        logic ao;
        logic eo;
        logic su;
        logic bi;
        logic oi;
        logic ce;
        logic co;
        logic j;
        logic fi;
    } ctrl_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LDA = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_STA = 4'd4,
        OP_LDI = 4'd5,
        OP_JMP = 4'd6,
        OP_JC  = 4'd7,
        OP_JZ  = 4'd8,
        OP_OUT = 4'd14,
        OP_HLT = 4'd15
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    // Fetch: MI|CO, then RO|II|CE
    localparam ctrl_t CTRL_FETCH0 = ctrl_t'(16'h4004);
    localparam ctrl_t CTRL_FETCH1 = ctrl_t'(16'h1408);

endpackage

// File: rtl/sap_microcode_rom.sv
// rtl/sap_microcode_rom.sv - Combinational microcode decode; EARLY_FETCH_EN selects per-opcode last step.
module sap_microcode_rom
    import sap_pkg::*;
#(
    parameter int STEPS = 5,
    localparam int SW = $clog2(STEPS)
) (
    input  logic [3:0]    opcode,
    input  logic [SW-1:0] step,
    input  logic          flag_c,
    input  logic          flag_z,
    output ctrl_t         ctrl,
    output logic [SW-1:0] last_step
);

    opcode_e    op;
    logic [7:0] s;

    assign op = opcode_e'(opcode);
    assign s  = 8'(step);

    always_comb begin
        ctrl = '0;
        case (s)
            8'd0: ctrl = CTRL_FETCH0;
            8'd1: ctrl = CTRL_FETCH1;
            8'd2: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl.io = 1'b1;
                        ctrl.mi = 1'b1;
                    end
                    OP_LDI: begin
                        ctrl.io = 1'b1;
                        ctrl.ai = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl.io = 1'b1;
                        ctrl.j  = 1'b1;
                    end
                    OP_JC: begin
                        ctrl.io = flag_c;
                        ctrl.j  = flag_c;
                    end
                    OP_JZ: begin
                        ctrl.io = flag_z;
                        ctrl.j  = flag_z;
                    end
                    OP_OUT: begin
                        ctrl.ao = 1'b1;
                        ctrl.oi = 1'b1;
                    end
                    OP_HLT:  ctrl.hlt = 1'b1;
                    default: ctrl = '0;
                endcase
            end
            8'd3: begin
                case (op)
                    OP_LDA: begin
                        ctrl.ro = 1'b1;
                        ctrl.ai = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl.ro = 1'b1;
                        ctrl.bi = 1'b1;
                    end
                    OP_STA: begin
                        ctrl.ao = 1'b1;
                        ctrl.ri = 1'b1;
                    end
                    default: ctrl = '0;
                endcase
            end
            8'd4: begin
                if (op == OP_ADD || op == OP_SUB) begin
                    ctrl.eo = 1'b1;
                    ctrl.ai = 1'b1;
                    ctrl.fi = 1'b1;
                    ctrl.su = (op == OP_SUB);
                end
            end
            default: ctrl = '0;
        endcase
    end

`ifdef EARLY_FETCH_EN
    // Conditional jumps keep last=2 even when not taken so timing is flag-independent
    always_comb begin
        case (op)
            OP_LDA, OP_STA: last_step = SW'(3);
            OP_ADD, OP_SUB: last_step = SW'(4);
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_step = SW'(2);
            default: last_step = SW'(1);
        endcase
    end
`else
    assign last_step = SW'(STEPS - 1);
`endif

endmodule

// File: rtl/sap_control_sequencer.sv
// rtl/sap_control_sequencer.sv - T-state FSM and step counter driving the SAP control word.
module sap_control_sequencer
    import sap_pkg::*;
#(
    parameter int STEPS = 5,
    localparam int SW = $clog2(STEPS)
) (
    input  logic          CLOCK_50,
    input  logic          rst_n,
    input  logic          run_en,
    input  logic [3:0]    opcode,
    input  logic          flag_c,
    input  logic          flag_z,
    output ctrl_t         ctrl,
    output logic [SW-1:0] step,
    output logic          cycle_end,
    output logic          halted
);

    state_e        state_q, state_d;
    logic [SW-1:0] step_q, step_d;
    ctrl_t         rom_ctrl;
    logic [SW-1:0] last_step;

    sap_microcode_rom #(.STEPS(STEPS)) u_rom (
        .opcode    (opcode),
        .step      (step_q),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .ctrl      (rom_ctrl),
        .last_step (last_step)
    );

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        ctrl      = '0;
        cycle_end = 1'b0;
        halted    = 1'b0;
        case (state_q)
            IDLE: begin
                if (run_en) begin
                    state_d = RUN;
                    step_d  = '0;
                end
            end
            RUN: begin
                ctrl      = rom_ctrl;
                cycle_end = (step_q == last_step);
                // Step holds on the halting tick so the frozen state shows where HLT hit
                if (run_en) begin
                    if (rom_ctrl.hlt) begin
                        state_d = HALT;
                    end else if (step_q == last_step) begin
                        step_d = '0;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
            end
            HALT: halted = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    assign step = step_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// tb/tb_sap_control_sequencer.sv - Random and directed checks of the sequencer against a table-driven model.
module tb_sap_control_sequencer;

    localparam int STEPS = 5;

    localparam logic [15:0] B_HLT = 16'h8000, B_MI = 16'h4000, B_RI = 16'h2000, B_RO = 16'h1000;
    localparam logic [15:0] B_IO  = 16'h0800, B_II = 16'h0400, B_AI = 16'h0200, B_AO = 16'h0100;
    localparam logic [15:0] B_EO  = 16'h0080, B_SU = 16'h0040, B_BI = 16'h0020, B_OI = 16'h0010;
    localparam logic [15:0] B_CE  = 16'h0008, B_CO = 16'h0004, B_J  = 16'h0002, B_FI = 16'h0001;

`ifdef EARLY_FETCH_EN
    localparam logic EARLY = 1'b1;
`else
    localparam logic EARLY = 1'b0;
`endif

    logic        CLOCK_50 = 1'b0;
    logic        rst_n;
    logic        run_en;
    logic [3:0]  opcode;
    logic        flag_c;
    logic        flag_z;
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        cycle_end;
    logic        halted;

    int total = 0;
    int bad   = 0;

    // Model: microcode steps 2..4 per opcode (unconditional form), 0=idle 1=run 2=halt
    logic [15:0] tbl [16][3];
    int          m_state;
    int          m_step;

    always #10 CLOCK_50 = ~CLOCK_50;

    sap_control_sequencer #(.STEPS(STEPS)) dut (
        .CLOCK_50  (CLOCK_50),
        .rst_n     (rst_n),
        .run_en    (run_en),
        .opcode    (opcode),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .ctrl      (ctrl),
        .step      (step),
        .cycle_end (cycle_end),
        .halted    (halted)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ucode(input int op, input int s, input logic c, input logic z);
        if (s == 0) return B_MI | B_CO;
        if (s == 1) return B_RO | B_II | B_CE;
        if (s > 4) return 16'h0;
        if ((op == 7 && !c) || (op == 8 && !z)) return 16'h0;
        return tbl[op][s-2];
    endfunction

    function automatic int last_of(input int op);
        int l;
        if (!EARLY) return STEPS - 1;
        l = 1;
        for (int s = 2; s <= 4; s++)
            if (tbl[op][s-2] != 16'h0) l = s;
        return l;
    endfunction

    function automatic logic [15:0] exp_ctrl();
        if (m_state != 1) return 16'h0;
        return ucode(int'(opcode), m_step, flag_c, flag_z);
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_ctrl"}, ctrl, exp_ctrl());
        check({tag, "_step"}, 16'(step), 16'(m_step));
        check({tag, "_cend"}, 16'(cycle_end), 16'((m_state == 1) && (m_step == last_of(int'(opcode)))));
        check({tag, "_halt"}, 16'(halted), 16'(m_state == 2));
    endtask

    // One clock: drive, check at negedge, advance model on posedge, leave at posedge+1
    task automatic cycle(input logic en, input logic [3:0] op, input logic c, input logic z);
        logic [15:0] e;
        int          l;
        run_en = en;
        opcode = op;
        flag_c = c;
        flag_z = z;
        @(negedge CLOCK_50);
        check_outputs("cyc");
        e = exp_ctrl();
        l = last_of(int'(op));
        @(posedge CLOCK_50);
        if (en) begin
            if (m_state == 0) begin
                m_state = 1;
                m_step  = 0;
            end else if (m_state == 1) begin
                if (e[15]) m_state = 2;
                else m_step = (m_step == l) ? 0 : m_step + 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        run_en  = 1'b0;
        rst_n   = 1'b0;
        m_state = 0;
        m_step  = 0;
        #1;
        check("rst_step", 16'(step), 16'h0);
        check("rst_ctrl", ctrl, 16'h0);
        check("rst_halt", 16'(halted), 16'h0);
        check("rst_cend", 16'(cycle_end), 16'h0);
        @(negedge CLOCK_50);
        rst_n = 1'b1;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic run_to(input logic [3:0] op, input logic c, input logic z, input int target);
        int n;
        n = 0;
        while ((m_step != target || m_state != 1) && n < 20) begin
            cycle(1'b1, op, c, z);
            n++;
        end
        check("reach_step", 16'(step), 16'(target));
    endtask

    initial begin
        int          cur_op;
        logic        en;
        for (int o = 0; o < 16; o++)
            for (int s = 0; s < 3; s++) tbl[o][s] = 16'h0;
        tbl[1][0] = B_IO | B_MI; tbl[1][1] = B_RO | B_AI;
        tbl[2][0] = B_IO | B_MI; tbl[2][1] = B_RO | B_BI; tbl[2][2] = B_EO | B_AI | B_FI;
        tbl[3][0] = B_IO | B_MI; tbl[3][1] = B_RO | B_BI; tbl[3][2] = B_EO | B_AI | B_SU | B_FI;
        tbl[4][0] = B_IO | B_MI; tbl[4][1] = B_AO | B_RI;
        tbl[5][0] = B_IO | B_AI;
        tbl[6][0] = B_IO | B_J;
        tbl[7][0] = B_IO | B_J;
        tbl[8][0] = B_IO | B_J;
        tbl[14][0] = B_AO | B_OI;
        tbl[15][0] = B_HLT;

        rst_n = 1'b0; run_en = 1'b0; opcode = 4'd0; flag_c = 1'b0; flag_z = 1'b0;
        m_state = 0; m_step = 0;
        @(posedge CLOCK_50);
        #1;
        do_reset();

        // LDA sequence, reset mid-instruction, restart
        cycle(1'b1, 4'd1, 1'b0, 1'b0);
        check("lda_s0", ctrl, B_MI | B_CO);
        run_to(4'd1, 1'b0, 1'b0, 3);
        check("lda_s3", ctrl, B_RO | B_AI);
        do_reset();
        cycle(1'b1, 4'd1, 1'b0, 1'b0);
        check("restart_s0", ctrl, B_MI | B_CO);
        run_to(4'd1, 1'b0, 1'b0, 3);
        cycle(1'b1, 4'd1, 1'b0, 1'b0);
        check("lda_after_s3", 16'(step), EARLY ? 16'd0 : 16'd4);
        if (!EARLY) begin
            check("lda_s4_ctrl", ctrl, 16'h0);
            check("lda_s4_cend", 16'(cycle_end), 16'h1);
            cycle(1'b1, 4'd1, 1'b0, 1'b0);
            check("lda_wrap", 16'(step), 16'h0);
        end

        // Conditional jumps with both flag values
        for (int k = 0; k < 4; k++) begin
            logic [3:0] op;
            logic       f;
            op = (k < 2) ? 4'd7 : 4'd8;
            f  = k[0];
            run_to(4'd0, 1'b0, 1'b0, 0);
            run_to(op, f && op == 4'd7, f && op == 4'd8, 2);
            check("jcond_s2", ctrl, f ? (B_IO | B_J) : 16'h0);
            run_to(op, f && op == 4'd7, f && op == 4'd8, 0);
        end

        // ADD stalled at s3
        run_to(4'd2, 1'b0, 1'b0, 3);
        for (int i = 0; i < 10; i++) cycle(1'b0, 4'd2, 1'b0, 1'b0);
        check("stall_step", 16'(step), 16'd3);
        check("stall_ctrl", ctrl, B_RO | B_BI);
        cycle(1'b1, 4'd2, 1'b0, 1'b0);
        check("add_s4", ctrl, B_EO | B_AI | B_FI);
        run_to(4'd2, 1'b0, 1'b0, 0);

        // LDI: last step depends on build option
        run_to(4'd5, 1'b0, 1'b0, 2);
        check("ldi_s2_cend", 16'(cycle_end), EARLY ? 16'h1 : 16'h0);
        cycle(1'b1, 4'd5, 1'b0, 1'b0);
        check("ldi_after_s2", 16'(step), EARLY ? 16'd0 : 16'd3);
        run_to(4'd5, 1'b0, 1'b0, 0);

        // HLT freezes everything
        run_to(4'd15, 1'b0, 1'b0, 2);
        check("hlt_s2", ctrl, B_HLT);
        cycle(1'b1, 4'd15, 1'b0, 1'b0);
        check("hlt_halted", 16'(halted), 16'h1);
        check("hlt_ctrl", ctrl, 16'h0);
        for (int i = 0; i < 20; i++)
            cycle(1'b1, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
        check("hlt_step_frozen", 16'(step), 16'd2);
        do_reset();

        // Random program stream
        cur_op = 0;
        for (int i = 0; i < 3000; i++) begin
            if (m_state == 2) do_reset();
            if (m_step == 0) begin
                cur_op = $urandom_range(0, 14);
                if ($urandom_range(0, 49) == 0) cur_op = 15;
            end
            en = ($urandom_range(0, 3) != 0);
            cycle(en, 4'(cur_op), 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
